maxpool_seq: RTL and testbench
==============================

// Module: maxpool_seq
// PURPOSE
//  Window sequencer and initiator for the maxpool datapath. Accepts a valid/ready sample
//   stream and groups it into windows of win_len samples.
//  Drives maxpool's max_clr/max_pool/I and captures its O at each window end.
//  Emits one registered result per window on a valid/ready output; runs num_win windows per start.
// PARAMETERS
//  N   32  sample/result width; two's complement, matches maxpool N
//  LW  8   width of win_len and the beat counter
//  LC  16  width of num_win and the window counter
// PORTS
//  clk        in   1   clock; all logic on posedge
//  rst_n      in   1   synchronous active-low reset
//  start      in   1   begin a job; sampled only in IDLE
//  win_len    in   LW  samples per window; latched at start; 0 is treated as 1
//  num_win    in   LC  windows per job; latched at start
//  busy       out  1   high in RUN and CAPT
//  done       out  1   one-cycle pulse when the job completes
//  in_valid   in   1   sample valid
//  in_data    in   N   signed sample
//  in_ready   out  1   sample accepted when in_valid && in_ready
//  mp_clr     out  1   to maxpool max_clr
//  mp_pool    out  1   to maxpool max_pool
//  mp_i       out  N   to maxpool I
//  mp_o       in   N   from maxpool O; registered there, so it reflects the previous cycle's drive
//  out_valid  out  1   result valid; held until out_ready
//  out_data   out  N   signed window maximum; stable while out_valid && !out_ready
//  out_ready  in   1   result consumed when out_valid && out_ready
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, counters=0, out_valid=0, out_data=0, done=0, busy=0.
//   Reset mid-job aborts the job; partial window and held result are discarded.
//  States:
//   IDLE: start -> latch params, beat=0, win=0.
//    If num_win==0: done=1 next cycle, stay IDLE. Otherwise go to RUN.
//   RUN: in_ready=1. Each accepted beat increments beat.
//    Accepted beat at beat==win_len-1 -> CAPT, beat=0.
//   CAPT: in_ready=0. Waits until !out_valid || out_ready.
//    Then: out_data<=mp_o, out_valid<=1, win++.
//    win==num_win-1 -> IDLE with done pulse; else -> RUN.
//  maxpool drive (combinational from state/beat/handshake):
//   IDLE: mp_clr=1, mp_pool=0, mp_i=0 (maxpool O forced to 0).
//   RUN, accepted beat, beat==0: mp_clr=0, mp_pool=0, mp_i=in_data (window load).
//   RUN, accepted beat, beat>0: mp_clr=0, mp_pool=1, mp_i=in_data (running max).
//   RUN with no accept, or CAPT: mp_clr=0, mp_pool=1, mp_i=-2^(N-1) (hold; O unchanged).
//  Latency: last beat accepted in cycle t; mp_o valid in t+1; out_valid high from t+2 if the
//   output register is free. Throughput is win_len+1 cycles per window with no stalls.
//  Output register: out_valid clears on out_valid && out_ready unless reloaded the same cycle.
//   Simultaneous consume and capture is allowed, giving back-to-back results.
//  start while busy: ignored. in_valid gaps: beat holds and the running max is preserved.
//  Comparison is signed; max of equal values is that value. win_len==1 passes samples through.
// CONFIGURATION
//  MAXPOOL_SEQ_RELU_EN defined: the first beat of each window drives mp_clr=1, mp_pool=1.
//   maxpool then computes max(0,in_data), so each window result is max(0, window max)
//   (fused ReLU). All other drive is unchanged.
//  Undefined: the first beat uses mp_pool=0 (plain load); negative maxima pass through.
// TESTING
//  1. win_len=4, num_win=1, in=3,-7,9,2, out_ready=1 -> one result 9, out_valid 2 cycles
//     after beat 4, done pulse.
//  2. win_len=4, in=-5,-2,-8,-3 -> -2. With MAXPOOL_SEQ_RELU_EN -> 0.
//  3. win_len=2, num_win=3, in=1,4,7,2,-1,-6, out_ready=0 until third window pending ->
//     in_ready low in CAPT; results 4,7,-1 in order, none lost.
//  4. win_len=3, in_valid toggled every other cycle, in=5,8,6 -> 8; mp_pool=1 with
//     mp_i=-2^31 on idle cycles.
//  5. rst_n=0 after 2 beats of a window, then a new job win_len=1, num_win=2, in=-3,10 ->
//     results -3,10; no stale output.
//  6. num_win=0 -> done pulse 1 cycle after start, out_valid never asserted;
//     start during busy -> ignored.

Source files
------------

// File: rtl/maxpool_seq.sv
// Window sequencer for the maxpool datapath: groups a sample stream into windows and
// returns one registered maximum per window. Define MAXPOOL_SEQ_RELU_EN for fused ReLU.
module maxpool_seq #(
    parameter int N  = 32,
    parameter int LW = 8,
    parameter int LC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] win_len,
    input  logic [LC-1:0] num_win,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          mp_clr,
    output logic          mp_pool,
    output logic [N-1:0]  mp_i,
    input  logic [N-1:0]  mp_o,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

    localparam logic [LW-1:0] ONE_LW  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LC-1:0] ONE_LC  = {{(LC-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  NEG_MIN = {1'b1, {(N-1){1'b0}}};

    state_t        state_r, state_s;
    logic [LW-1:0] beat_r, beat_s, len_r, len_s;
    logic [LC-1:0] win_r, win_s, nwin_r, nwin_s;
    logic          out_valid_r, out_valid_s;
    logic [N-1:0]  out_data_r, out_data_s;
    logic          done_r, done_s;
    logic          accept_s;

    // Next-state, counters and output-register update
    always_comb begin
        state_s     = state_r;
        beat_s      = beat_r;
        len_s       = len_r;
        win_s       = win_r;
        nwin_s      = nwin_r;
        out_data_s  = out_data_r;
        done_s      = 1'b0;
        accept_s    = (state_r == ST_RUN) && in_valid;
        // A consumed result frees the register unless a capture reloads it below.
        if (out_valid_r && out_ready) begin
            out_valid_s = 1'b0;
        end else begin
            out_valid_s = out_valid_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    len_s  = (win_len == {LW{1'b0}}) ? ONE_LW : win_len;
                    nwin_s = num_win;
                    beat_s = {LW{1'b0}};
                    win_s  = {LC{1'b0}};
                    if (num_win == {LC{1'b0}}) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    if (beat_r == len_r - ONE_LW) begin
                        beat_s  = {LW{1'b0}};
                        state_s = ST_CAPT;
                    end else begin
                        beat_s = beat_r + ONE_LW;
                    end
                end else begin
                    beat_s = beat_r;
                end
            end
            ST_CAPT: begin
                if (!out_valid_r || out_ready) begin
                    out_data_s  = mp_o;
                    out_valid_s = 1'b1;
                    win_s       = win_r + ONE_LC;
                    if (win_r == nwin_r - ONE_LC) begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_CAPT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // maxpool drive: clear in IDLE, load/accumulate on accepted beats, hold otherwise
    always_comb begin
        mp_clr  = 1'b0;
        mp_pool = 1'b1;
        mp_i    = NEG_MIN;
        if (state_r == ST_IDLE) begin
            mp_clr  = 1'b1;
            mp_pool = 1'b0;
            mp_i    = {N{1'b0}};
        end else if (accept_s) begin
            mp_i = in_data;
            if (beat_r == {LW{1'b0}}) begin
`ifdef MAXPOOL_SEQ_RELU_EN
                mp_clr  = 1'b1;
                mp_pool = 1'b1;
`else
                mp_clr  = 1'b0;
                mp_pool = 1'b0;
`endif
            end else begin
                mp_clr  = 1'b0;
                mp_pool = 1'b1;
            end
        end else begin
            mp_clr  = 1'b0;
            mp_pool = 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            beat_r      <= {LW{1'b0}};
            len_r       <= {LW{1'b0}};
            win_r       <= {LC{1'b0}};
            nwin_r      <= {LC{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {N{1'b0}};
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            beat_r      <= beat_s;
            len_r       <= len_s;
            win_r       <= win_s;
            nwin_r      <= nwin_s;
            out_valid_r <= out_valid_s;
            out_data_r  <= out_data_s;
            done_r      <= done_s;
        end
    end

    assign busy      = (state_r != ST_IDLE);
    assign in_ready  = (state_r == ST_RUN);
    assign done      = done_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_maxpool_seq.sv
// Scoreboard bench for maxpool_seq with a behavioural maxpool model on the mp_* interface.
module tb_maxpool_seq;

    localparam logic [31:0] NEG_MIN = 32'h8000_0000;
`ifdef MAXPOOL_SEQ_RELU_EN
    localparam logic [31:0] EXP_T2 = 32'd0;
    localparam logic [31:0] EXP_M1 = 32'd0;
    localparam logic [31:0] EXP_M3 = 32'd0;
`else
    localparam logic [31:0] EXP_T2 = -32'sd2;
    localparam logic [31:0] EXP_M1 = -32'sd1;
    localparam logic [31:0] EXP_M3 = -32'sd3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  win_len = 8'd0;
    logic [15:0] num_win = 16'd0;
    logic        busy, done;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic        mp_clr, mp_pool;
    logic [31:0] mp_i;
    logic [31:0] mp_o;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    maxpool_seq #(.N(32), .LW(8), .LC(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len), .num_win(num_win),
        .busy(busy), .done(done), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mp_clr(mp_clr), .mp_pool(mp_pool), .mp_i(mp_i),
        .mp_o(mp_o), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Behavioural maxpool: registered O
    always_ff @(posedge clk) begin
        if (!rst_n) mp_o <= 32'd0;
        else begin
            case ({mp_clr, mp_pool})
                2'b10:   mp_o <= 32'd0;
                2'b11:   mp_o <= ($signed(mp_i) > 32'sd0) ? mp_i : 32'd0;
                2'b00:   mp_o <= mp_i;
                default: mp_o <= ($signed(mp_i) > $signed(mp_o)) ? mp_i : mp_o;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(exp));
        end
    endtask

    // Monitor: pop expected result on each output handshake; check stall stability
    logic        stalled = 1'b0;
    logic [31:0] held = 32'd0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (stalled) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", out_data, 32'hDEAD_BEEF);
                end else begin
                    chk("result", out_data, exp_q.pop_front());
                end
            end
            stalled = out_valid && !out_ready;
            held    = out_data;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic start_job(input logic [7:0] len, input logic [15:0] nw);
        start = 1'b1; win_len = len; num_win = nw;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] v);
        bit ok = 1'b0;
        in_valid = 1'b1; in_data = v;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 32'd0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        chk("done_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mp_clr", {31'd0, mp_clr}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic window, latency and done pulse
        exp_q.push_back(32'd9);
        start_job(8'd4, 16'd1);
        send(32'd3); send(-32'sd7); send(32'd9); send(32'd2);
        @(negedge clk);
        chk("t1_capt_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_capt_valid", {31'd0, out_valid}, 32'd0);
        chk("t1_capt_mp_i", mp_i, NEG_MIN);
        chk("t1_capt_mp_pool", {31'd0, mp_pool}, 32'd1);
        @(negedge clk);
        chk("t1_valid_lat", {31'd0, out_valid}, 32'd1);
        chk("t1_done", {31'd0, done}, 32'd1);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // 2: all-negative window
        exp_q.push_back(EXP_T2);
        start_job(8'd4, 16'd1);
        send(-32'sd5); send(-32'sd2); send(-32'sd8); send(-32'sd3);
        wait_done();
        @(posedge clk); #1;

        // 3: back-pressure across three windows
        out_ready = 1'b0;
        exp_q.push_back(32'd4); exp_q.push_back(32'd7); exp_q.push_back(EXP_M1);
        start_job(8'd2, 16'd3);
        send(32'd1); send(32'd4); send(32'd7); send(32'd2);
        repeat (4) begin
            @(negedge clk);
            chk("t3_stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("t3_stall_data", out_data, 32'd4);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(-32'sd1); send(-32'sd6);
        wait_done();
        repeat (2) @(negedge clk);
        chk("t3_drained", exp_q.size(), 32'd0);
        @(posedge clk); #1;

        // 4: gaps between beats keep the running max
        exp_q.push_back(32'd8);
        start_job(8'd3, 16'd1);
        send(32'd5);
        @(negedge clk);
        chk("t4_gap_pool", {31'd0, mp_pool}, 32'd1);
        chk("t4_gap_clr", {31'd0, mp_clr}, 32'd0);
        chk("t4_gap_mp_i", mp_i, NEG_MIN);
        @(posedge clk); #1;
        send(32'd8);
        @(negedge clk);
        chk("t4_gap2_mp_i", mp_i, NEG_MIN);
        @(posedge clk); #1;
        send(32'd6);
        wait_done();
        @(posedge clk); #1;

        // 5: reset mid-window, then pass-through job
        start_job(8'd4, 16'd1);
        send(32'd11); send(32'd12);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_data", out_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(EXP_M3); exp_q.push_back(32'd10);
        start_job(8'd1, 16'd2);
        send(-32'sd3); send(32'd10);
        wait_done();
        @(posedge clk); #1;

        // win_len 0 behaves as 1
        exp_q.push_back(32'd6);
        start_job(8'd0, 16'd1);
        send(32'd6);
        wait_done();
        @(posedge clk); #1;

        // 6: empty job and start while busy
        start_job(8'd3, 16'd0);
        @(negedge clk);
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("t6_done_pulse", {31'd0, done}, 32'd0);
        chk("t6_no_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        exp_q.push_back(32'd3);
        start_job(8'd2, 16'd1);
        start_job(8'd5, 16'd9);
        send(32'd3); send(32'd1);
        wait_done();
        repeat (3) @(negedge clk);
        chk("t6_busy_idle", {31'd0, busy}, 32'd0);
        chk("final_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
